// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32 memory-stage load/store unit with a req/ack data bus
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W accesses (adds MisalignM);
// without it, halfword and word addresses are force-aligned.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusBe,
  input  logic [31:0] BusRData,
  input  logic        BusAck
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        MisalignM
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Last counter value before the timeout fires; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_uns_q, ld_uns_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              access;
  logic [1:0]        off;
  logic              is_b;
  logic              is_h;
  logic              is_w;
  logic              misalign;
  logic              start;
  logic              timeout_hit;
  logic [3:0]        be_fmt;
  logic [31:0]       wdata_fmt;
  logic [31:0]       load_ext;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign access = MemReadM | MemWriteM;
  assign off    = ALUResultM[1:0];
  assign is_b   = (funct3M[1:0] == 2'b00);
  assign is_h   = (funct3M[1:0] == 2'b01);
  assign is_w   = ~is_b & ~is_h;

`ifdef MISALIGN_TRAP_EN
  assign misalign = access & ((is_h & off[0]) | (is_w & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Reset gates the launch so every output reads 0 while reset is held.
  assign start       = (state_q == S_IDLE) & access & ~misalign & ~reset;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // State and bus-field registers; BusReq drops as soon as reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      ld_size_q <= '0;
      ld_uns_q  <= 1'b0;
      ld_off_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_off_q  <= ld_off_d;
      rdata_q   <= rdata_d;
    end
  end

  // Place store data into byte lanes; loads always request the whole word.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = 32'b0;
    if (MemWriteM) begin
      if (is_b) begin
        be_fmt    = 4'b0001 << off;
        wdata_fmt = {4{WriteDataM[7:0]}};
      end else if (is_h) begin
        be_fmt    = 4'b0011 << {off[1], 1'b0};
        wdata_fmt = {2{WriteDataM[15:0]}};
      end else begin
        wdata_fmt = WriteDataM;
      end
    end
  end

  // Next-state logic: launch, wait for ack or timeout, then one completion cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    ld_off_d  = ld_off_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = MemWriteM;
          addr_d    = {ALUResultM[31:2], 2'b00};
          wdata_d   = wdata_fmt;
          be_d      = be_fmt;
          ld_size_d = funct3M[1:0];
          ld_uns_d  = funct3M[2];
          ld_off_d  = off;
        end
      end
      S_REQ: begin
        if (BusAck) begin
          rdata_d = BusRData;
          req_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pick the addressed byte/half from the captured word and extend it.
  always_comb begin
    byte_sel = rdata_q[{ld_off_q, 3'b000} +: 8];
    half_sel = ld_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (ld_size_q)
      2'b00:   load_ext = {{24{~ld_uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~ld_uns_q & half_sel[15]}}, half_sel};
      default: load_ext = rdata_q;
    endcase
  end

  // Pipeline-facing outputs decoded from the current state.
  always_comb begin
    StallM    = start | (state_q == S_REQ);
    BusErrM   = (state_q == S_ERR);
    ReadDataM = 32'b0;
    if ((state_q == S_RESP) && !we_q) begin
      ReadDataM = load_ext;
    end
  end

  assign BusReq   = req_q;
  assign BusWe    = we_q;
  assign BusAddr  = addr_q;
  assign BusWData = wdata_q;
  assign BusBe    = be_q;

`ifdef MISALIGN_TRAP_EN
  assign MisalignM = (state_q == S_IDLE) & misalign & ~reset;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu against a byte-level model
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BusErrM;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusBe;
  logic [31:0] BusRData;
  logic        BusAck;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .BusErrM    (BusErrM),
    .BusReq     (BusReq),
    .BusWe      (BusWe),
    .BusAddr    (BusAddr),
    .BusWData   (BusWData),
    .BusBe      (BusBe),
    .BusRData   (BusRData),
    .BusAck     (BusAck)
`ifdef MISALIGN_TRAP_EN
    ,
    .MisalignM  (MisalignM)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Access size in bytes from funct3 (anything not B or H is a word).
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Offset rounded down to the access size (force alignment).
  function automatic int eff_off(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = size_of(f3);
    return (int'(addr[1:0]) / sz) * sz;
  endfunction

  function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int be;
    if (!wr) return 4'hF;
    be = ((1 << size_of(f3)) - 1) << eff_off(f3, addr);
    return be[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input bit wr, input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    r  = '0;
    sz = size_of(f3);
    if (wr) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    longint v;
    longint span;
    int sz;
    sz   = size_of(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'(rd) >> (8 * eff_off(f3, addr))) % span;
    if (!f3[2] && sz < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Runs one access starting just after a clock edge in IDLE; ack_at=0 means no ack.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdat, input int ack_at);
    int k;
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    BusAck     = 1'b0;
    #1;
`ifdef MISALIGN_TRAP_EN
    if ((size_of(f3) == 2 && addr[0]) || (size_of(f3) == 4 && addr[1:0] != 2'b00)) begin
      check_eq("mis_flag", MisalignM, 1);
      check_eq("mis_stall", StallM, 0);
      check_eq("mis_rdata", ReadDataM, 0);
      @(posedge clk); #1;
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      #1;
      check_eq("mis_noreq", BusReq, 0);
      check_eq("mis_stall2", StallM, 0);
      return;
    end
    check_eq("mis_clear", MisalignM, 0);
`endif
    check_eq("idle_stall", StallM, 1);
    check_eq("idle_req", BusReq, 0);
    k = 0;
    while (1) begin
      k++;
      @(posedge clk); #1;
      BusAck   = (k == ack_at);
      BusRData = (k == ack_at) ? rdat : $urandom;
      #1;
      check_eq("req_req", BusReq, 1);
      check_eq("req_we", BusWe, wr);
      check_eq("req_addr", BusAddr, {addr[31:2], 2'b00});
      check_eq("req_be", BusBe, model_be(wr, f3, addr));
      check_eq("req_wdata", BusWData, model_wdata(wr, f3, wd));
      check_eq("req_stall", StallM, 1);
      check_eq("req_rdata0", ReadDataM, 0);
      if (k == ack_at || k >= TO) break;
    end
    @(posedge clk); #1;
    BusAck    = 1'b0;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    #1;
    check_eq("done_stall", StallM, 0);
    check_eq("done_req", BusReq, 0);
    if (ack_at != 0) begin
      check_eq("resp_err", BusErrM, 0);
      check_eq("resp_rdata", ReadDataM, wr ? 32'h0 : model_load(f3, addr, rdat));
    end else begin
      check_eq("err_pulse", BusErrM, 1);
      check_eq("err_rdata", ReadDataM, 0);
      @(posedge clk); #2;
      check_eq("err_once", BusErrM, 0);
      check_eq("err_idle", StallM, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] f3s [8];
    logic [31:0] a;
    int n;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    reset      = 1'b1;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    funct3M    = 3'b000;
    ALUResultM = '0;
    WriteDataM = '0;
    BusRData   = '0;
    BusAck     = 1'b0;
    #2;
    check_eq("rst_req", BusReq, 0);
    check_eq("rst_stall", StallM, 0);
    check_eq("rst_err", BusErrM, 0);
    check_eq("rst_rdata", ReadDataM, 0);
    check_eq("rst_addr", BusAddr, 0);
    check_eq("rst_be", BusBe, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases: LW, LB/LBU sign handling, SH lanes with slow ack, timeout.
    do_access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1);
    check_eq("t1_literal", model_load(3'b010, 32'h100, 32'hDEAD_BEEF), 32'hDEAD_BEEF);
    @(posedge clk); #1;
    do_access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);
    @(posedge clk); #1;
    do_access(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2);
    @(posedge clk); #1;
    do_access(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3);
    @(posedge clk); #1;
    do_access(1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'h1111_2222, 0);
    @(posedge clk); #1;
    do_access(1, 0, 3'b101, 32'h0000_0302, 32'h0, 32'h8001_7FFF, TO);

    // Ack outside REQ must not start or complete anything.
    @(posedge clk); #1;
    BusAck = 1'b1;
    @(posedge clk); #1;
    BusAck = 1'b0;
    #1;
    check_eq("stray_ack_req", BusReq, 0);
    check_eq("stray_ack_stall", StallM, 0);

    // Reset in the second REQ cycle, then a normal load.
    @(posedge clk); #1;
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h0000_0400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_req", BusReq, 0);
    check_eq("midrst_stall", StallM, 0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    do_access(1, 0, 3'b010, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 2);

`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #1;
    do_access(1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 1);
`else
    @(posedge clk); #1;
    do_access(1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h0BAD_CAFE, 1);
`endif

    // Random mix of loads, stores, idle cycles and timeouts.
    for (int it = 0; it < 80; it++) begin
      @(posedge clk); #1;
      n = $urandom_range(0, 9);
      a = $urandom;
      if (n == 0) begin
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        #1;
        check_eq("rnd_idle_stall", StallM, 0);
      end else begin
        do_access(n < 6, n >= 5, f3s[$urandom_range(0, 7)], a, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
